// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of the 5-stage RV32 pipeline.
// Issues loads/stores on a valid/ready request channel, formats load data and
// drives the MEM/WB register; stalls upstream while memory is busy.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses raise a trap
// pulse (trap_valid/trap_addr) instead of issuing a request.
module mem_stage_lsu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RSP_TO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mem_dm_en,
  input  logic            mem_mux_rd,
  input  logic            mem_regfile_en,
  input  logic [2:0]      mem_func3,
  input  logic [4:0]      mem_rd_index,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_write_data,
  output logic            dm_req_valid,
  input  logic            dm_req_ready,
  output logic [XLEN-1:0] dm_req_addr,
  output logic [3:0]      dm_req_wstrb,
  output logic [XLEN-1:0] dm_req_wdata,
  input  logic            dm_rsp_valid,
  input  logic [XLEN-1:0] dm_rsp_rdata,
  output logic            stall_out,
  output logic            wb_regfile_en,
  output logic [4:0]      wb_rd_index,
  output logic [XLEN-1:0] wb_rd_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_addr
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t          state;
  logic            is_store;
  logic            is_load;
  logic            mem_op;
  logic            rsp_timeout;
  logic [31:0]     rsp_cnt;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] fmt_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic            misalign;
`endif

  // Operation classification and misalignment detection
  always_comb begin
    is_store = |mem_dm_en;
    is_load  = mem_mux_rd & mem_regfile_en & ~is_store;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = 1'b0;
    if (is_load | is_store) begin
      if (mem_func3[1:0] == 2'b01)
        misalign = mem_alu_result[0];
      else if (mem_func3[1:0] != 2'b00)
        misalign = |mem_alu_result[1:0];
    end
    mem_op = (is_load | is_store) & ~misalign;
`else
    mem_op = is_load | is_store;
`endif
    rsp_timeout = (RSP_TO != 0) && (rsp_cnt == RSP_TO - 1);
  end

  // Request fields are pure functions of the (frozen) EX/MEM inputs
  always_comb begin
    dm_req_addr  = {mem_alu_result[XLEN-1:2], 2'b00};
    dm_req_wstrb = is_store ? mem_dm_en : 4'b0000;
    dm_req_wdata = mem_write_data;
  end

  // Request valid and upstream stall per state; both forced low during reset
  always_comb begin
    dm_req_valid = 1'b0;
    stall_out    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          dm_req_valid = mem_op;
          stall_out    = mem_op & (is_load | ~dm_req_ready);
        end
        REQ: begin
          dm_req_valid = 1'b1;
          stall_out    = is_load | ~dm_req_ready;
        end
        RSP: stall_out = ~dm_rsp_valid & ~rsp_timeout;
        default: begin
          dm_req_valid = 1'b0;
          stall_out    = 1'b0;
        end
      endcase
    end
  end

  // Load formatting: byte lane by addr[1:0], halfword by addr[1]
  always_comb begin
    byte_v = dm_rsp_rdata[{mem_alu_result[1:0], 3'b000} +: 8];
    half_v = mem_alu_result[1] ? dm_rsp_rdata[31:16] : dm_rsp_rdata[15:0];
    case (mem_func3)
      3'b000:  fmt_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  fmt_data = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  fmt_data = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  fmt_data = {{(XLEN-16){1'b0}}, half_v};
      default: fmt_data = dm_rsp_rdata;
    endcase
  end

  // FSM plus MEM/WB register; write enable defaults low so every stalled
  // cycle writes a bubble and nothing retires twice
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wb_regfile_en <= 1'b0;
      wb_rd_index   <= '0;
      wb_rd_data    <= '0;
      rsp_cnt       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_valid    <= 1'b0;
      trap_addr     <= '0;
`endif
    end else begin
      wb_regfile_en <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_valid    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (is_load | is_store) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (misalign) begin
              trap_valid <= 1'b1;
              trap_addr  <= mem_alu_result;
            end else
`endif
            if (dm_req_ready) begin
              state   <= is_load ? RSP : IDLE;
              rsp_cnt <= '0;
            end else begin
              state <= REQ;
            end
          end else begin
            wb_regfile_en <= mem_regfile_en;
            wb_rd_index   <= mem_rd_index;
            wb_rd_data    <= mem_alu_result;
          end
        end
        REQ: begin
          if (dm_req_ready) begin
            state   <= is_load ? RSP : IDLE;
            rsp_cnt <= '0;
          end
        end
        RSP: begin
          if (dm_rsp_valid) begin
            wb_regfile_en <= 1'b1;
            wb_rd_index   <= mem_rd_index;
            wb_rd_data    <= fmt_data;
            state         <= IDLE;
          end else if (rsp_timeout) begin
            state <= IDLE;
          end else begin
            rsp_cnt <= rsp_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of mem_stage_lsu against a
// transaction-level reference. Build macro MEM_MISALIGN_TRAP_EN adds trap checks.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_dm_en;
  logic        mem_mux_rd;
  logic        mem_regfile_en;
  logic [2:0]  mem_func3;
  logic [4:0]  mem_rd_index;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [31:0] dm_req_addr;
  logic [3:0]  dm_req_wstrb;
  logic [31:0] dm_req_wdata;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_rdata;
  logic        stall_out;
  logic        wb_regfile_en;
  logic [4:0]  wb_rd_index;
  logic [31:0] wb_rd_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        trap_valid;
  logic [31:0] trap_addr;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  mem_stage_lsu #(.XLEN(32), .RSP_TO(0)) dut (
    .clk(clk), .rst(rst),
    .mem_dm_en(mem_dm_en), .mem_mux_rd(mem_mux_rd), .mem_regfile_en(mem_regfile_en),
    .mem_func3(mem_func3), .mem_rd_index(mem_rd_index),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_req_addr(dm_req_addr), .dm_req_wstrb(dm_req_wstrb), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
    .stall_out(stall_out), .wb_regfile_en(wb_regfile_en),
    .wb_rd_index(wb_rd_index), .wb_rd_data(wb_rd_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .trap_valid(trap_valid), .trap_addr(trap_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load result, computed arithmetically from the RV32 load rules
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b < 128) ? b : b - 256;
      3'd1:    return (h < 32768) ? h : h - 65536;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic set_nop();
    mem_dm_en = 4'h0; mem_mux_rd = 1'b0; mem_regfile_en = 1'b0; mem_func3 = 3'd0;
    mem_rd_index = 5'd0; mem_alu_result = 32'h0; mem_write_data = 32'h0;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_rdata = 32'h0;
  endtask

  // One EX/MEM instruction from presentation to retirement; called #1 after a posedge
  task automatic run_op(input logic [3:0] dm_en, input logic mux_rd, input logic rf_en,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] exp_data);
    logic st;
    logic ld;
    st = (dm_en != 4'h0);
    ld = mux_rd && rf_en && !st;
    mem_dm_en = dm_en; mem_mux_rd = mux_rd; mem_regfile_en = rf_en; mem_func3 = f3;
    mem_rd_index = rd; mem_alu_result = addr; mem_write_data = wdata;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
    if (!st && !ld) begin
      dm_rsp_valid = $urandom_range(0, 1);
      @(negedge clk);
      chk("alu_req_valid", dm_req_valid, 0);
      chk("alu_stall", stall_out, 0);
      @(posedge clk); #1;
      dm_rsp_valid = 1'b0;
      chk("alu_wb_en", wb_regfile_en, rf_en);
      chk("alu_wb_rd", wb_rd_index, rd);
      chk("alu_wb_data", wb_rd_data, addr);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      dm_req_ready = (i == rdy_dly);
      dm_rsp_valid = (i != rdy_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("req_valid", dm_req_valid, 1);
      chk("req_stall", stall_out, ld ? 1 : (i < rdy_dly));
      chk("req_addr", dm_req_addr, addr & 32'hFFFF_FFFC);
      chk("req_wstrb", dm_req_wstrb, st ? dm_en : 4'h0);
      chk("req_wdata", dm_req_wdata, wdata);
      if (i > 0) chk("req_bubble", wb_regfile_en, 0);
      @(posedge clk); #1;
    end
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
    if (st) begin
      chk("st_wb_en", wb_regfile_en, 0);
      return;
    end
    for (int j = 1; j <= rsp_dly; j++) begin
      dm_rsp_valid = (j == rsp_dly);
      dm_rsp_rdata = (j == rsp_dly) ? rdata : $urandom;
      @(negedge clk);
      chk("rsp_req_valid", dm_req_valid, 0);
      chk("rsp_stall", stall_out, j < rsp_dly);
      chk("rsp_bubble", wb_regfile_en, 0);
      @(posedge clk); #1;
    end
    dm_rsp_valid = 1'b0;
    chk("ld_wb_en", wb_regfile_en, 1);
    chk("ld_wb_rd", wb_rd_index, rd);
    chk("ld_wb_data", wb_rd_data, exp_data);
  endtask

  initial begin
    logic [3:0]  r_en;
    logic        r_mux;
    logic        r_rf;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    int          k;

    set_nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en", wb_regfile_en, 0);
    chk("rst_wb_rd", wb_rd_index, 0);
    chk("rst_wb_data", wb_rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", dm_req_valid, 0);
    chk("rst_stall", stall_out, 0);
    @(posedge clk); #1;

    // ALU op, sw with ready held off, byte/half loads
    run_op(4'h0, 1'b0, 1'b1, 3'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0, 1, 32'h0);
    run_op(4'hF, 1'b0, 1'b0, 3'd2, 5'd0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 3, 1, 32'h0);
    run_op(4'h0, 1'b1, 1'b1, 3'd0, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 2, 32'hFFFF_FF80);
    run_op(4'h0, 1'b1, 1'b1, 3'd4, 5'd8, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 2, 32'h0000_0080);
    run_op(4'h0, 1'b1, 1'b1, 3'd1, 5'd9, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 1, 32'hFFFF_8001);

    // Spurious response in IDLE with a non-writing op
    set_nop();
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0;
    chk("spurious_wb_en", wb_regfile_en, 0);

    // Reset while waiting for a response; the late response must be dropped
    run_op(4'h0, 1'b0, 1'b1, 3'd0, 5'd3, 32'h0000_0ABC, 32'h0, 32'h0, 0, 1, 32'h0);
    mem_mux_rd = 1'b1; mem_regfile_en = 1'b1; mem_func3 = 3'd2; mem_rd_index = 5'd4;
    mem_alu_result = 32'h0000_0200; dm_req_ready = 1'b1;
    @(posedge clk); #1;
    dm_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rsp_req_valid", dm_req_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();
    chk("rst_rsp_wb_en", wb_regfile_en, 0);
    chk("rst_rsp_wb_rd", wb_rd_index, 0);
    chk("rst_rsp_wb_data", wb_rd_data, 0);
    @(negedge clk);
    chk("rst_rsp_stall", stall_out, 0);
    chk("rst_rsp_valid_idle", dm_req_valid, 0);
    @(posedge clk); #1;
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0;
    chk("late_rsp_wb_en", wb_regfile_en, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without issuing a request
    mem_mux_rd = 1'b1; mem_regfile_en = 1'b1; mem_func3 = 3'd2; mem_rd_index = 5'd6;
    mem_alu_result = 32'h0000_0102; dm_req_ready = 1'b1;
    @(negedge clk);
    chk("trap_req_valid", dm_req_valid, 0);
    chk("trap_stall", stall_out, 0);
    @(posedge clk); #1;
    set_nop();
    chk("trap_valid", trap_valid, 1);
    chk("trap_addr", trap_addr, 32'h0000_0102);
    chk("trap_wb_en", wb_regfile_en, 0);
    @(posedge clk); #1;
    chk("trap_pulse", trap_valid, 0);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 2);
      r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_rdata = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      r_addr = r_addr & 32'hFFFF_FFFC;
`endif
      if (k == 0) begin
        r_en = 4'h0; r_mux = 1'($urandom_range(0, 1));
        r_rf = r_mux ? 1'b0 : 1'($urandom_range(0, 1));
      end else if (k == 1) begin
        r_en = 4'($urandom_range(1, 15)); r_mux = 1'($urandom_range(0, 1));
        r_rf = 1'($urandom_range(0, 1));
      end else begin
        r_en = 4'h0; r_mux = 1'b1; r_rf = 1'b1;
      end
      run_op(r_en, r_mux, r_rf, r_f3, 5'($urandom_range(0, 31)), r_addr, $urandom, r_rdata,
             $urandom_range(0, 3), $urandom_range(1, 3), ref_load(r_f3, r_addr, r_rdata));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule
